// File: rtl/ir_cmd_filter_pkg.sv
// Shared SIRC field layout, state encoding and counter sizing helper for ir_cmd_filter.
package ir_cmd_filter_pkg;

  localparam int unsigned IR_WORD_W   = 12;
  localparam int unsigned IR_CMD_MSB  = 6;
  localparam int unsigned IR_CMD_LSB  = 0;
  localparam int unsigned IR_ADDR_MSB = 11;
  localparam int unsigned IR_ADDR_LSB = 7;
  localparam int unsigned IR_ADDR_W   = IR_ADDR_MSB - IR_ADDR_LSB + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ir_cmd_filter_rise_detect.sv
// Rising-edge strobe on a level input; the previous-value register resets to RST_VAL
// so a level already high when reset releases does not produce a strobe.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise_c
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= RST_VAL;
    else     r_prev <= i_d;
  end

  assign o_rise_c = i_d & ~r_prev;

endmodule

// File: rtl/ir_cmd_filter.sv
// SIRC command filter: address match, repeat-frame collapse, gap-timeout release.
// Optional typematic auto-repeat when IR_CMD_FILTER_AUTOREPEAT_EN is defined.
module ir_cmd_filter
  import ir_cmd_filter_pkg::*;
#(
  parameter logic [IR_ADDR_W-1:0] ADDR        = 5'h01,
  parameter bit                   ADDR_MATCH  = 1'b1,
  parameter int unsigned          GAP_CYCLES  = 3_000_000,
  parameter int unsigned          HOLD_CYCLES = 25_000_000,
  parameter int unsigned          RPT_CYCLES  = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IR_WORD_W-1:0] data,
  input  logic                 data_rdy,
  output logic                 new_cmd,
  output logic [IR_WORD_W-1:0] cmd_buf,
  output logic                 held
);

  localparam int unsigned GAP_W = cnt_w(GAP_CYCLES);

  state_t               r_state, w_state_nxt;
  logic [GAP_W-1:0]     r_gap, w_gap_nxt;
  logic [IR_WORD_W-1:0] w_cmd_buf_nxt;
  logic                 w_new_cmd_nxt;
  logic                 w_event;
  logic                 w_addr_ok;
  logic                 w_accept;
  logic                 w_new_key;
  logic                 w_gap_done;

  rise_detect #(.RST_VAL(1'b1)) u_rise (
    .clk      (clk),
    .rst      (rst),
    .i_d      (data_rdy),
    .o_rise_c (w_event)
  );

  assign w_addr_ok  = !ADDR_MATCH || (data[IR_ADDR_MSB:IR_ADDR_LSB] == ADDR);
  assign w_accept   = w_event && w_addr_ok;
  assign w_new_key  = w_accept && (data != cmd_buf);
  assign w_gap_done = (r_gap == GAP_W'(GAP_CYCLES - 1));

`ifdef IR_CMD_FILTER_AUTOREPEAT_EN
  localparam int unsigned HOLD_W = cnt_w((HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES);

  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_rpt, w_rpt_nxt;
  logic              w_tick;

  // First tick uses the press delay, later ticks the repeat period.
  assign w_tick = r_rpt ? (r_hold == HOLD_W'(RPT_CYCLES - 1))
                        : (r_hold == HOLD_W'(HOLD_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(HOLD_CYCLES), 32'(RPT_CYCLES)};
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_nxt     = r_gap;
    w_cmd_buf_nxt = cmd_buf;
    w_new_cmd_nxt = 1'b0;
`ifdef IR_CMD_FILTER_AUTOREPEAT_EN
    w_hold_nxt    = r_hold;
    w_rpt_nxt     = r_rpt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = ST_HELD;
          w_cmd_buf_nxt = data;
          w_new_cmd_nxt = 1'b1;
          w_gap_nxt     = '0;
`ifdef IR_CMD_FILTER_AUTOREPEAT_EN
          w_hold_nxt    = '0;
          w_rpt_nxt     = 1'b0;
`endif
        end
      end
      ST_HELD: begin
        if (w_new_key) begin
          w_cmd_buf_nxt = data;
          w_new_cmd_nxt = 1'b1;
          w_gap_nxt     = '0;
`ifdef IR_CMD_FILTER_AUTOREPEAT_EN
          w_hold_nxt    = '0;
          w_rpt_nxt     = 1'b0;
`endif
        end else if (!w_accept && w_gap_done) begin
          // Release wins over a coincident repeat tick.
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_accept)            w_gap_nxt = '0;
          else if (r_gap != '1)    w_gap_nxt = r_gap + GAP_W'(1);
`ifdef IR_CMD_FILTER_AUTOREPEAT_EN
          if (w_tick) begin
            w_new_cmd_nxt = 1'b1;
            w_hold_nxt    = '0;
            w_rpt_nxt     = 1'b1;
          end else begin
            w_hold_nxt    = r_hold + HOLD_W'(1);
          end
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      cmd_buf <= '0;
      new_cmd <= 1'b0;
      held    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      cmd_buf <= w_cmd_buf_nxt;
      new_cmd <= w_new_cmd_nxt;
      held    <= (w_state_nxt == ST_HELD);
    end
  end

`ifdef IR_CMD_FILTER_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_rpt  <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_rpt  <= w_rpt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ir_cmd_filter.sv
// Directed bench for ir_cmd_filter (GAP=20, HOLD=50, RPT=10); honours IR_CMD_FILTER_AUTOREPEAT_EN.
module tb_ir_cmd_filter;

  logic        clk;
  logic        rst;
  logic [11:0] data;
  logic        data_rdy;
  logic        new_cmd;
  logic [11:0] cmd_buf;
  logic        held;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int pulses[$];

  ir_cmd_filter #(
    .ADDR        (5'h01),
    .ADDR_MATCH  (1'b1),
    .GAP_CYCLES  (20),
    .HOLD_CYCLES (50),
    .RPT_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .data_rdy (data_rdy),
    .new_cmd  (new_cmd),
    .cmd_buf  (cmd_buf),
    .held     (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (new_cmd === 1'b1) pulses.push_back(cyc);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise data_rdy over one active edge; outputs of that edge are visible on return.
  task automatic frame(input logic [11:0] w);
    data     = w;
    data_rdy = 1'b1;
    @(posedge clk);
    #1;
    data_rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; data_rdy = 1'b1; data = 12'h095;
    tick(3);
    rst = 1'b0;
    tick(3);
    n_cmp++; if (new_cmd !== 1'b0) begin n_err++; $display("FAIL reset_new_cmd got=%b exp=0", new_cmd); end
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL reset_held got=%b exp=0", held); end
    n_cmp++; if (cmd_buf !== 12'h000) begin n_err++; $display("FAIL reset_cmd_buf got=%h exp=000", cmd_buf); end
    data_rdy = 1'b0;
    tick(2);
  endtask

  task automatic test_single_press;
    int exp_n;
    pulses.delete();
    frame(12'h095);
    n_cmp++; if (new_cmd !== 1'b1) begin n_err++; $display("FAIL press_pulse got=%b exp=1", new_cmd); end
    n_cmp++; if (cmd_buf !== 12'h095) begin n_err++; $display("FAIL press_cmd_buf got=%h exp=095", cmd_buf); end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL press_held got=%b exp=1", held); end
    tick(1);
    n_cmp++; if (new_cmd !== 1'b0) begin n_err++; $display("FAIL press_pulse_width got=%b exp=0", new_cmd); end
    tick(13);
    for (int k = 1; k <= 3; k++) begin
      frame(12'h095);
      n_cmp++; if (new_cmd !== 1'b0) begin n_err++; $display("FAIL repeat_frame_%0d got=%b exp=0", k, new_cmd); end
      if (k < 3) tick(14);
    end
    tick(19);
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL gap_before_release got=%b exp=1", held); end
    tick(1);
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL gap_release got=%b exp=0", held); end
    n_cmp++; if (cmd_buf !== 12'h095) begin n_err++; $display("FAIL release_keeps_buf got=%h exp=095", cmd_buf); end
`ifdef IR_CMD_FILTER_AUTOREPEAT_EN
    exp_n = 3;
`else
    exp_n = 1;
`endif
    n_cmp++; if (pulses.size() != exp_n) begin n_err++; $display("FAIL press_pulse_count got=%0d exp=%0d", pulses.size(), exp_n); end
    tick(3);
  endtask

  task automatic test_addr_filter;
    frame(12'h095);
    tick(9);
    frame(12'h115);
    n_cmp++; if (new_cmd !== 1'b0) begin n_err++; $display("FAIL addr_reject_pulse got=%b exp=0", new_cmd); end
    n_cmp++; if (cmd_buf !== 12'h095) begin n_err++; $display("FAIL addr_reject_buf got=%h exp=095", cmd_buf); end
    tick(9);
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL addr_reject_held got=%b exp=1", held); end
    tick(1);
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL addr_reject_no_restart got=%b exp=0", held); end
    tick(3);
  endtask

  task automatic test_new_key;
    frame(12'h095);
    tick(4);
    frame(12'h092);
    n_cmp++; if (new_cmd !== 1'b1) begin n_err++; $display("FAIL new_key_pulse got=%b exp=1", new_cmd); end
    n_cmp++; if (cmd_buf !== 12'h092) begin n_err++; $display("FAIL new_key_buf got=%h exp=092", cmd_buf); end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL new_key_held got=%b exp=1", held); end
    tick(19);
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL new_key_gap_restart got=%b exp=1", held); end
    tick(1);
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL new_key_release got=%b exp=0", held); end
    tick(3);
  endtask

  task automatic test_autorepeat;
    int l;
    int exp_q[$];
    pulses.delete();
    frame(12'h095);
    l = cyc;
    for (int k = 1; k <= 6; k++) begin
      tick(14);
      frame(12'h095);
    end
    tick(40);
`ifdef IR_CMD_FILTER_AUTOREPEAT_EN
    exp_q = '{l, l + 50, l + 60, l + 70, l + 80, l + 90, l + 100};
`else
    exp_q = '{l};
`endif
    n_cmp++; if (pulses.size() != exp_q.size()) begin n_err++; $display("FAIL repeat_count got=%0d exp=%0d", pulses.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
      n_cmp++; if (pulses[i] != exp_q[i]) begin n_err++; $display("FAIL repeat_time_%0d got=latch+%0d exp=latch+%0d", i, pulses[i] - l, exp_q[i] - l); end
    end
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL repeat_release got=%b exp=0", held); end
  endtask

  task automatic test_reset_mid_hold;
    frame(12'h095);
    tick(5);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL async_rst_held got=%b exp=0", held); end
    n_cmp++; if (cmd_buf !== 12'h000) begin n_err++; $display("FAIL async_rst_buf got=%h exp=000", cmd_buf); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);
    frame(12'h095);
    n_cmp++; if (new_cmd !== 1'b1) begin n_err++; $display("FAIL post_rst_pulse got=%b exp=1", new_cmd); end
    n_cmp++; if (cmd_buf !== 12'h095) begin n_err++; $display("FAIL post_rst_buf got=%h exp=095", cmd_buf); end
    tick(25);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_addr_filter();
    test_new_key();
    test_autorepeat();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
